// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between two requesters.
// Optional WAIT-state timeout abort is enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic              r1_err,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              grant;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`else
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // On a tie the requester not served last wins; otherwise whichever is asking.
  assign grant = (r0_req && r1_req) ? ~last_q : r1_req;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          owner_d     = grant;
          mem_we_d    = grant ? r1_we    : r0_we;
          mem_addr_d  = grant ? r1_addr  : r0_addr;
          mem_wdata_d = grant ? r1_wdata : r0_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        cnt_d = '0;
        err_d = 1'b0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          if (!mem_we_q) begin
            if (owner_q) r1_rdata_d = mem_rdata;
            else         r0_rdata_d = mem_rdata;
          end
          last_d  = owner_q;
          state_d = S_RESP;
        end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        // mem_done is checked first so a completion on the expiry cycle wins.
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            last_d  = owner_q;
            state_d = S_RESP;
          end
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_start = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign r0_done   = (state_q == S_RESP) && !owner_q;
  assign r1_done   = (state_q == S_RESP) &&  owner_q;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  assign r0_err    = r0_done && err_q;
  assign r1_err    = r1_done && err_q;
`else
  assign r0_err    = 1'b0;
  assign r1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, randomized traffic against a
// transaction-level model, and the timeout corner when MEM_PORT_ARBITER_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic        mem_start, mem_we, mem_done, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_rdata (r0_rdata),
    .r0_done  (r0_done),
    .r0_err   (r0_err),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_rdata (r1_rdata),
    .r1_done  (r1_done),
    .r1_err   (r1_err),
    .mem_start(mem_start),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rs, q0, w0;
    logic [31:0] a0;
    logic        q1, w1;
    logic [31:0] a1, wd;
    logic        md;
    logic [31:0] mrd;
    logic        st, d0, d1, ow, mwe;
    logic [31:0] ma, mwd, rd0, rd1;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic add(input logic rs, q0, w0, input logic [31:0] a0,
                     input logic q1, w1, input logic [31:0] a1, wd,
                     input logic md, input logic [31:0] mrd,
                     input logic st, d0, d1, ow, mwe,
                     input logic [31:0] ma, mwd, rd0, rd1);
    vec_t v;
    v.rs = rs; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.q1 = q1; v.w1 = w1; v.a1 = a1;
    v.wd = wd; v.md = md; v.mrd = mrd; v.st = st; v.d0 = d0; v.d1 = d1; v.ow = ow;
    v.mwe = mwe; v.ma = ma; v.mwd = mwd; v.rd0 = rd0; v.rd1 = rd1;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    mem_done = 0; mem_rdata = '0;
  endtask

  task automatic set_pins(input int i, input logic rq, input txn_t t);
    if (i == 0) begin
      r0_req = rq; r0_we = t.we; r0_addr = t.addr; r0_wdata = t.wdata;
    end else begin
      r1_req = rq; r1_we = t.we; r1_addr = t.addr; r1_wdata = t.wdata;
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = $urandom & 32'hFF;
    t.wdata = $urandom;
    return t;
  endfunction

  // Transaction-level model state for the random phase.
  bit          rq[2];
  txn_t        cur[2];
  txn_t        act;
  logic [31:0] exp_rd[2];
  bit          outstanding, done_now, done_next, idle_now, last_m, own_m, start_exp;
  int unsigned cyc, done_at;
  int unsigned n_to;
  bit          got;

  initial begin
    rst = 1;
    idle_inputs();

    // rs q0 w0 a0  q1 w1 a1  wd  md mrd | st d0 d1 ow mwe ma mwd rd0 rd1
    add(1,0,0,32'h00, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h00,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h10, 0,0,32'h00, 32'h0,        0,32'h0,        1,0,0,0,0, 32'h10,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h10, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h10,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h10, 0,0,32'h00, 32'h0,        1,32'hDEADBEEF, 0,1,0,0,0, 32'h10,32'h0,        32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h10, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h10,32'h0,        32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h10, 0,0,32'h00, 32'h0,        1,32'hBAD0BAD0, 0,0,0,0,0, 32'h10,32'h0,        32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h10, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h10,32'h0,        32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h00, 1,1,32'h20, 32'h12345678, 0,32'h0,        1,0,0,1,1, 32'h20,32'h12345678, 32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h00, 1,0,32'h99, 32'hFFFFFFFF, 0,32'h0,        0,0,0,1,1, 32'h20,32'h12345678, 32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h00, 1,0,32'h77, 32'hFFFFFFFF, 0,32'h0,        0,0,0,1,1, 32'h20,32'h12345678, 32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h00, 1,1,32'h20, 32'h12345678, 1,32'hCAFEF00D, 0,0,1,1,1, 32'h20,32'h12345678, 32'hDEADBEEF, 32'h0);
    add(0,0,0,32'h00, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,1,1, 32'h20,32'h12345678, 32'hDEADBEEF, 32'h0);
    add(0,1,0,32'h30, 0,0,32'h00, 32'h0,        0,32'h0,        1,0,0,0,0, 32'h30,32'h0,        32'hDEADBEEF, 32'h0);
    add(0,1,0,32'h30, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h30,32'h0,        32'hDEADBEEF, 32'h0);
    add(1,0,0,32'h30, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h00,32'h0,        32'h0,        32'h0);
    add(0,0,0,32'h00, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h00,32'h0,        32'h0,        32'h0);
    add(0,0,0,32'h00, 0,0,32'h00, 32'h0,        1,32'h55AA55AA, 0,0,0,0,0, 32'h00,32'h0,        32'h0,        32'h0);
    add(0,0,0,32'h00, 0,0,32'h00, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h00,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        1,0,0,0,0, 32'h40,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h40,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h40,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h40,32'h0,        32'h0,        32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        1,32'h11111111, 0,1,0,0,0, 32'h40,32'h0,        32'h11111111, 32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,0,0, 32'h40,32'h0,        32'h11111111, 32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        1,0,0,1,0, 32'h50,32'h0,        32'h11111111, 32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,1,0, 32'h50,32'h0,        32'h11111111, 32'h0);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        1,32'h22222222, 0,0,1,1,0, 32'h50,32'h0,        32'h11111111, 32'h22222222);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        0,0,0,1,0, 32'h50,32'h0,        32'h11111111, 32'h22222222);
    add(0,1,0,32'h40, 1,0,32'h50, 32'h0,        0,32'h0,        1,0,0,0,0, 32'h40,32'h0,        32'h11111111, 32'h22222222);

    foreach (vecs[i]) begin
      rst = vecs[i].rs;
      r0_req = vecs[i].q0; r0_we = vecs[i].w0; r0_addr = vecs[i].a0; r0_wdata = vecs[i].wd;
      r1_req = vecs[i].q1; r1_we = vecs[i].w1; r1_addr = vecs[i].a1; r1_wdata = vecs[i].wd;
      mem_done = vecs[i].md; mem_rdata = vecs[i].mrd;
      tick();
      chk1 ($sformatf("v%0d mem_start", i), mem_start, vecs[i].st);
      chk1 ($sformatf("v%0d r0_done", i),   r0_done,   vecs[i].d0);
      chk1 ($sformatf("v%0d r1_done", i),   r1_done,   vecs[i].d1);
      chk1 ($sformatf("v%0d owner", i),     owner,     vecs[i].ow);
      chk1 ($sformatf("v%0d mem_we", i),    mem_we,    vecs[i].mwe);
      chk32($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].ma);
      chk32($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].mwd);
      chk32($sformatf("v%0d r0_rdata", i),  r0_rdata,  vecs[i].rd0);
      chk32($sformatf("v%0d r1_rdata", i),  r1_rdata,  vecs[i].rd1);
      chk1 ($sformatf("v%0d r0_err", i),    r0_err,    1'b0);
      chk1 ($sformatf("v%0d r1_err", i),    r1_err,    1'b0);
    end

    // Randomized traffic against the transaction-level model.
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    rq[0] = 0; rq[1] = 0;
    cur[0] = '0; cur[1] = '0; act = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    outstanding = 0; done_now = 0; idle_now = 1; last_m = 1; own_m = 0;
    cyc = 0; done_at = 0;

    for (int unsigned n = 0; n < 3000; n++) begin
      mem_done  = 0;
      mem_rdata = $urandom;
      done_next = 0;
      if (outstanding && cyc == done_at) begin
        mem_done  = 1;
        done_next = 1;
        if (!act.we) exp_rd[own_m] = mem_rdata;
      end else if (!outstanding && $urandom_range(0, 7) == 0) begin
        mem_done = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (done_now && int'(own_m) == i) begin
          rq[i] = 1'($urandom_range(0, 1));
          if (rq[i]) cur[i] = rand_txn();
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i]  = 1;
          cur[i] = rand_txn();
        end
        if (outstanding && int'(own_m) == i) set_pins(i, rq[i], rand_txn());
        else                                 set_pins(i, rq[i], cur[i]);
      end

      tick();
      cyc++;

      start_exp = idle_now && (rq[0] || rq[1]);
      if (start_exp) begin
        own_m       = (rq[0] && rq[1]) ? ~last_m : rq[1];
        act         = cur[own_m];
        outstanding = 1;
        done_at     = cyc + $urandom_range(1, 4);
      end
      chk1("rnd mem_start", mem_start, start_exp);
      chk1("rnd owner", owner, own_m);
      if (outstanding) begin
        chk1 ("rnd mem_we",    mem_we,    act.we);
        chk32("rnd mem_addr",  mem_addr,  act.addr);
        chk32("rnd mem_wdata", mem_wdata, act.wdata);
      end
      if (done_next) begin
        last_m      = own_m;
        outstanding = 0;
      end
      chk1 ("rnd r0_done",  r0_done,  done_next && !own_m);
      chk1 ("rnd r1_done",  r1_done,  done_next &&  own_m);
      chk1 ("rnd r0_err",   r0_err,   1'b0);
      chk1 ("rnd r1_err",   r1_err,   1'b0);
      chk32("rnd r0_rdata", r0_rdata, exp_rd[0]);
      chk32("rnd r1_rdata", r1_rdata, exp_rd[1]);
      done_now = done_next;
      idle_now = !outstanding && !done_now;
    end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Memory never answers: abort after 4 WAIT cycles, then a normal read follows.
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
    r0_req = 1; r0_addr = 32'h60;
    got = 0; n_to = 0;
    for (int unsigned k = 1; k <= 20 && !got; k++) begin
      tick();
      if (r0_done) begin
        got  = 1;
        n_to = k;
        chk1 ("to r0_err",   r0_err,   1'b1);
        chk1 ("to r1_err",   r1_err,   1'b0);
        chk32("to r0_rdata", r0_rdata, 32'h0);
      end
    end
    chk1 ("to done seen", got, 1'b1);
    chk32("to done cycle", n_to, 32'd6);
    r0_req = 0;
    tick();
    chk1("to done width", r0_done, 1'b0);
    r0_req = 1; r0_addr = 32'h64;
    tick();
    chk1("to2 mem_start", mem_start, 1'b1);
    tick();
    mem_done = 1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_done = 0; r0_req = 0;
    chk1 ("to2 r0_done",  r0_done,  1'b1);
    chk1 ("to2 r0_err",   r0_err,   1'b0);
    chk32("to2 r0_rdata", r0_rdata, 32'hA5A5A5A5);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
